temp_alarm_fsm_param: RTL



---
 rtl/temp_alarm_fsm_param.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/temp_alarm_fsm_param.sv
// temp_alarm_fsm_param
// Room-temperature alarm state machine with N_LVL thermometer threshold
// inputs, debounced ambient level, fan/LED decodes and a latched
// body-temperature alarm. Exports a state code for the display driver.
// Optional build macro: TEMP_HYST_EN -- when defined, a downward level
// change must be stable for 2*DEB_CNT cycles before it commits.
module temp_alarm_fsm_param #(
  parameter int N_LVL     = 3,
  parameter int LW        = 3,
  parameter int DEB_CNT   = 4,
  parameter int NOTIF_LVL = 1,
  parameter int ABAN_LVL  = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_LVL-1:0] t_lvl,
  input  logic             t_corp,
  input  logic             ack,
  output logic             notif,
  output logic             aban,
  output logic             alarm,
  output logic [LW-1:0]    lvl,
  output logic [2:0]       state1
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PEND   = 3'd1,
    ST_ACTIVE = 3'd2,
    ST_ALARM  = 3'd3
  } state_t;

  localparam logic [7:0] DEB_UP = 8'(DEB_CNT);
`ifdef TEMP_HYST_EN
  localparam logic [7:0] DEB_DN = 8'(2 * DEB_CNT);
`else
  localparam logic [7:0] DEB_DN = 8'(DEB_CNT);
`endif
  localparam logic [LW-1:0] NOTIF_L = LW'(NOTIF_LVL);
  localparam logic [LW-1:0] ABAN_L  = LW'(ABAN_LVL);

  // Registered state
  state_t          state_reg;
  logic [LW-1:0]   lvl_reg;
  logic [LW-1:0]   cand_reg;
  logic [7:0]      cnt_reg;
  logic            corp_cand_reg;
  logic            corp_deb_reg;
  logic [7:0]      corp_cnt_reg;
  logic            alarm_reg;
  logic            notif_reg;
  logic            aban_reg;

  // Next-state values
  state_t          state_next;
  logic [LW-1:0]   lvl_next;
  logic [LW-1:0]   cand_next;
  logic [7:0]      cnt_next;
  logic [7:0]      lvl_thr;
  logic            corp_cand_next;
  logic            corp_deb_next;
  logic [7:0]      corp_cnt_next;
  logic            alarm_next;

  // Priority encoder: each stage overrides the previous one when its bit is
  // set, so the highest set bit wins even for non-thermometer patterns.
  logic [LW-1:0] raw_chain [N_LVL+1];
  logic [LW-1:0] raw_lvl;

  assign raw_chain[0] = '0;
  for (genvar gi = 0; gi < N_LVL; gi++) begin : g_enc
    assign raw_chain[gi+1] = t_lvl[gi] ? LW'(gi + 1) : raw_chain[gi];
  end
  assign raw_lvl = raw_chain[N_LVL];

  // Level debounce: track candidate, count stable cycles, commit on threshold
  always_comb begin
    cand_next = cand_reg;
    cnt_next  = cnt_reg;
    lvl_next  = lvl_reg;
    if (raw_lvl != cand_reg) begin
      cand_next = raw_lvl;
      // Returning to the committed level cancels the pending change.
      cnt_next  = (raw_lvl == lvl_reg) ? 8'd0 : 8'd1;
    end else if (cand_reg != lvl_reg) begin
      if (cnt_reg != 8'hFF) cnt_next = cnt_reg + 8'd1;
    end
    lvl_thr = (cand_next < lvl_reg) ? DEB_DN : DEB_UP;
    if (cnt_next != 8'd0 && cnt_next >= lvl_thr) begin
      lvl_next = cand_next;
      cnt_next = 8'd0;
    end
  end

  // Body-temperature debounce with the same rules, plus the alarm latch
  always_comb begin
    corp_cand_next = corp_cand_reg;
    corp_cnt_next  = corp_cnt_reg;
    corp_deb_next  = corp_deb_reg;
    if (t_corp != corp_cand_reg) begin
      corp_cand_next = t_corp;
      corp_cnt_next  = (t_corp == corp_deb_reg) ? 8'd0 : 8'd1;
    end else if (corp_cand_reg != corp_deb_reg) begin
      if (corp_cnt_reg != 8'hFF) corp_cnt_next = corp_cnt_reg + 8'd1;
    end
    if (corp_cnt_next != 8'd0 && corp_cnt_next >= DEB_UP) begin
      corp_deb_next = corp_cand_next;
      corp_cnt_next = 8'd0;
    end
    // Set dominates; ack only clears once the debounced flag is low.
    alarm_next = corp_deb_next | (alarm_reg & ~ack);
  end

  // State selection by priority from the post-edge values
  always_comb begin
    if (alarm_next)              state_next = ST_ALARM;
    else if (cnt_next != 8'd0)   state_next = ST_PEND;
    else if (lvl_next != '0)     state_next = ST_ACTIVE;
    else                         state_next = ST_IDLE;
  end

  // All state and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      lvl_reg       <= '0;
      cand_reg      <= '0;
      cnt_reg       <= 8'd0;
      corp_cand_reg <= 1'b0;
      corp_deb_reg  <= 1'b0;
      corp_cnt_reg  <= 8'd0;
      alarm_reg     <= 1'b0;
      notif_reg     <= 1'b0;
      aban_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      lvl_reg       <= lvl_next;
      cand_reg      <= cand_next;
      cnt_reg       <= cnt_next;
      corp_cand_reg <= corp_cand_next;
      corp_deb_reg  <= corp_deb_next;
      corp_cnt_reg  <= corp_cnt_next;
      alarm_reg     <= alarm_next;
      notif_reg     <= (lvl_next >= NOTIF_L);
      aban_reg      <= (lvl_next >= ABAN_L);
    end
  end

  assign notif  = notif_reg;
  assign aban   = aban_reg;
  assign alarm  = alarm_reg;
  assign lvl    = lvl_reg;
  assign state1 = state_reg;

endmodule
